btn_debouncer: RTL and testbench

//   Front-end conditioning for the flappy_top push-buttons (BtnL/U/D/R/C).
//   Per button: 2-flop synchronise, counter-based debounce, then registered outputs:
//   a clean level and a single-cycle press pulse. The game FSM consumes the pulses
//   (flap, start, pause); the levels drive the Ld* status LEDs.

---
 rtl/btn_debouncer_pkg.sv | 20 ++
 rtl/btn_debounce_fsm.sv | 157 +++++++++++++++
 rtl/btn_debouncer.sv | 51 +++++
 tb/tb_btn_debouncer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/btn_debouncer_pkg.sv
// Shared definitions for the push-button conditioning front end.
//   - btn_state_e   : per-channel debounce FSM state encoding (3 bits)
//   - DEF_*         : default debounce / auto-repeat timing (100 MHz clock)
package btn_debouncer_pkg;

  typedef enum logic [2:0] {
    BTN_IDLE        = 3'd0,
    BTN_DEB_PRESS   = 3'd1,
    BTN_PULSE       = 3'd2,
    BTN_HELD        = 3'd3,
    BTN_DEB_RELEASE = 3'd4
  } btn_state_e;

  localparam int DEF_NUM_BTN         = 5;
  localparam int DEF_DEBOUNCE_CYCLES = 500000;    // 5 ms
  localparam int DEF_CNT_W           = 20;
  localparam int DEF_REPEAT_DELAY    = 50000000;  // 500 ms
  localparam int DEF_REPEAT_PERIOD   = 10000000;  // 100 ms

endpackage

// File: rtl/btn_debounce_fsm.sv
// One button channel: 2-flop synchroniser, counter-based debounce FSM and,
// when BTN_AUTOREPEAT_EN is defined, an auto-repeat timer active in HELD.
// Ports:
//   clk   in  system clock, rising edge
//   rst   in  asynchronous active-high reset
//   raw   in  raw asynchronous button input, 1 = pressed
//   level out debounced level
//   pulse out one-cycle strobe per accepted press (plus repeats if enabled)
// Macro: BTN_AUTOREPEAT_EN enables the repeat timer and its two parameters.
//
// state           | meaning
// BTN_IDLE        | released, waiting for s2=1
// BTN_DEB_PRESS   | s2=1 seen, counting stable-high cycles
// BTN_PULSE       | press accepted, one-cycle strobe
// BTN_HELD        | pressed, waiting for s2=0
// BTN_DEB_RELEASE | s2=0 seen, counting stable-low cycles
module btn_debounce_fsm
  import btn_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
`ifdef BTN_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic pulse
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1, s2;
  btn_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BTN_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Counter is cleared on every state change and compared with ==, so it
  // can never wrap.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      BTN_IDLE: begin
        if (s2) begin
          state_nxt = BTN_DEB_PRESS;
          cnt_nxt   = '0;
        end
      end
      BTN_DEB_PRESS: begin
        if (!s2) begin
          state_nxt = BTN_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = BTN_PULSE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      BTN_PULSE: begin
        state_nxt = BTN_HELD;
        cnt_nxt   = '0;
      end
      BTN_HELD: begin
        if (!s2) begin
          state_nxt = BTN_DEB_RELEASE;
          cnt_nxt   = '0;
        end
      end
      BTN_DEB_RELEASE: begin
        if (s2) begin
          state_nxt = BTN_HELD;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = BTN_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = BTN_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign level = (state == BTN_PULSE) || (state == BTN_HELD) ||
                 (state == BTN_DEB_RELEASE);

`ifdef BTN_AUTOREPEAT_EN
  // The repeat timer gets its own width so long repeat intervals do not
  // force a wide debounce counter.
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;
  localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

  logic [REP_W-1:0] rcnt;
  logic             rep_armed;  // first REPEAT_DELAY has elapsed
  logic             rep_pulse;

  // Counts only in HELD with the input still pressed; frozen in
  // DEB_RELEASE, restarted (including the initial delay) on HELD entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rcnt      <= '0;
      rep_armed <= 1'b0;
      rep_pulse <= 1'b0;
    end else if (state == BTN_HELD && s2) begin
      if (rcnt == (rep_armed ? PERIOD_LAST : DELAY_LAST)) begin
        rcnt      <= '0;
        rep_armed <= 1'b1;
        rep_pulse <= 1'b1;
      end else begin
        rcnt      <= rcnt + REP_W'(1);
        rep_pulse <= 1'b0;
      end
    end else begin
      rep_pulse <= 1'b0;
      if (state_nxt == BTN_HELD && state != BTN_HELD) begin
        rcnt      <= '0;
        rep_armed <= 1'b0;
      end
    end
  end

  assign pulse = (state == BTN_PULSE) || rep_pulse;
`else
  assign pulse = (state == BTN_PULSE);
`endif

endmodule

// File: rtl/btn_debouncer.sv
// Push-button conditioning for flappy_top: NUM_BTN independent channels,
// each synchronised and debounced, plus an OR of all press strobes.
// Ports:
//   ClkPort   in  system clock, rising edge
//   Reset     in  asynchronous active-high reset
//   btn_raw   in  raw button inputs, 1 = pressed
//   btn_level out debounced levels (status LEDs)
//   btn_pulse out one-cycle press strobes (game FSM)
//   any_pulse out OR of btn_pulse, same cycle
// Macro: BTN_AUTOREPEAT_EN adds REPEAT_DELAY / REPEAT_PERIOD auto-repeat.
module btn_debouncer
  import btn_debouncer_pkg::*;
#(
  parameter int NUM_BTN         = DEF_NUM_BTN,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
`ifdef BTN_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
`endif
) (
  input  logic               ClkPort,
  input  logic               Reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_pulse,
  output logic               any_pulse
);

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
    btn_debounce_fsm #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
`ifdef BTN_AUTOREPEAT_EN
      ,
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
`endif
    ) u_fsm (
      .clk  (ClkPort),
      .rst  (Reset),
      .raw  (btn_raw[g]),
      .level(btn_level[g]),
      .pulse(btn_pulse[g])
    );
  end

  assign any_pulse = |btn_pulse;

endmodule

// File: tb/tb_btn_debouncer.sv
module tb_btn_debouncer;

  localparam int NB  = 5;
  localparam int DEB = 4;
  localparam int RD  = 8;
  localparam int RP  = 3;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic          ClkPort = 1'b0;
  logic          Reset   = 1'b1;
  logic [NB-1:0] btn_raw = '0;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_pulse;
  logic          any_pulse;

  int vectors     = 0;
  int miscompares = 0;

  always #5 ClkPort = ~ClkPort;

  btn_debouncer #(
    .NUM_BTN        (NB),
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (4)
`ifdef BTN_AUTOREPEAT_EN
    ,
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
`endif
  ) dut (
    .ClkPort  (ClkPort),
    .Reset    (Reset),
    .btn_raw  (btn_raw),
    .btn_level(btn_level),
    .btn_pulse(btn_pulse),
    .any_pulse(any_pulse)
  );

  task automatic chk(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Reference model: accepted level flips after DEB+1 consecutive
  // disagreeing synchronised samples; the edge after an accepted press is
  // the strobe cycle and ignores the input. Repeats are scheduled from the
  // count of consecutive held-and-pressed samples.
  logic [NB-1:0] m_s1, m_s2, m_lvl, m_strobe, m_rep;
  int            m_run[NB];
  int            m_k[NB];

  always @(posedge ClkPort) begin
    if (Reset) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_strobe = '0; m_rep = '0;
      for (int i = 0; i < NB; i++) begin m_run[i] = 0; m_k[i] = 0; end
    end else begin
      for (int i = 0; i < NB; i++) begin
        logic v;
        bit   fire;
        v    = m_s2[i];
        fire = 1'b0;
        if (m_strobe[i]) begin
          m_strobe[i] = 1'b0;
          m_run[i]    = 0;
          m_k[i]      = 0;
        end else if (v != m_lvl[i]) begin
          m_k[i]   = 0;
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == DEB + 1) begin
            m_lvl[i]    = v;
            m_run[i]    = 0;
            m_strobe[i] = v;
          end
        end else begin
          if (v && m_run[i] == 0) begin
            m_k[i] = m_k[i] + 1;
            fire = (m_k[i] == RD) || (m_k[i] > RD && ((m_k[i] - RD) % RP) == 0);
          end else begin
            m_k[i] = 0;
          end
          m_run[i] = 0;
        end
        m_rep[i] = AR && fire;
      end
      m_s2 = m_s1;
      m_s1 = btn_raw;
    end
    #1;
    chk("level", btn_level, m_lvl);
    chk("pulse", btn_pulse, m_strobe | m_rep);
    chk("any",   NB'(any_pulse), NB'(|(m_strobe | m_rep)));
  end

  task automatic step(input int n);
    repeat (n) @(posedge ClkPort);
    #2;
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge ClkPort);
    chk("rst_level", btn_level, 5'b00000);
    chk("rst_pulse", btn_pulse, 5'b00000);
    chk("rst_any", NB'(any_pulse), 5'b00000);
    Reset = 1'b0;
    repeat (2) @(negedge ClkPort);

    // 1: single press, pulse 7 clocks after edge
    btn_raw[1] = 1'b1;
    step(6);
    chk("t1_pulse_pre", btn_pulse, 5'b00000);
    chk("t1_level_pre", btn_level, 5'b00000);
    step(1);
    chk("t1_pulse", btn_pulse, 5'b00010);
    chk("t1_level", btn_level, 5'b00010);
    chk("t1_any", NB'(any_pulse), 5'b00001);
    step(1);
    chk("t1_pulse_post", btn_pulse, 5'b00000);
    chk("t1_level_post", btn_level, 5'b00010);

    // 2: two-clock glitch on channel 0
    @(negedge ClkPort); btn_raw[0] = 1'b1;
    @(negedge ClkPort);
    @(negedge ClkPort); btn_raw[0] = 1'b0;
    step(12);
    chk("t2_level", btn_level, 5'b00010);

    // 3: release with bounce 0,1,0
    @(negedge ClkPort); btn_raw[1] = 1'b0;
    @(negedge ClkPort); btn_raw[1] = 1'b1;
    @(negedge ClkPort); btn_raw[1] = 1'b0;
    step(6);
    chk("t3_level_pre", btn_level, 5'b00010);
    step(1);
    chk("t3_level", btn_level, 5'b00000);

    // 4: simultaneous presses
    @(negedge ClkPort); btn_raw = 5'b10101;
    step(6);
    chk("t4_pulse_pre", btn_pulse, 5'b00000);
    step(1);
    chk("t4_pulse", btn_pulse, 5'b10101);
    chk("t4_any", NB'(any_pulse), 5'b00001);
    step(1);
    chk("t4_pulse_post", btn_pulse, 5'b00000);
    chk("t4_any_post", NB'(any_pulse), 5'b00000);

    // 5: reset in the middle of press debounce
    @(negedge ClkPort); btn_raw = 5'b00000;
    step(10);
    @(negedge ClkPort); btn_raw = 5'b00100;
    step(6);
    @(negedge ClkPort); Reset = 1'b1;
    step(1);
    chk("t5_rst_level", btn_level, 5'b00000);
    chk("t5_rst_pulse", btn_pulse, 5'b00000);
    @(negedge ClkPort); Reset = 1'b0;
    step(6);
    chk("t5_pulse_pre", btn_pulse, 5'b00000);
    step(1);
    chk("t5_pulse", btn_pulse, 5'b00100);
    chk("t5_level", btn_level, 5'b00100);

    // 6: long hold, auto-repeat only when enabled
    @(negedge ClkPort); btn_raw = 5'b00000;
    step(10);
    @(negedge ClkPort); btn_raw = 5'b01000;
    step(7);
    chk("t6_first", btn_pulse, 5'b01000);
    step(9);
    chk("t6_rep1", btn_pulse, AR ? 5'b01000 : 5'b00000);
    step(1);
    chk("t6_rep1_post", btn_pulse, 5'b00000);
    step(2);
    chk("t6_rep2", btn_pulse, AR ? 5'b01000 : 5'b00000);
    step(11);
    chk("t6_level", btn_level, 5'b01000);
    @(negedge ClkPort); btn_raw = 5'b00000;
    step(12);
    chk("t6_release", btn_level, 5'b00000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
